// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and the prefetch unit's fetch-state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam lc3b_word LC3B_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } prefetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction queue holding {ir, pc, next_pc}; head is read straight from storage.
module fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enq,
    input  logic                         deq,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             enq_ir,
    input  logic [WIDTH-1:0]             enq_pc,
    input  logic [WIDTH-1:0]             enq_next_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head_ir,
    output logic [WIDTH-1:0]             head_pc,
    output logic [WIDTH-1:0]             head_next_pc
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] ir_mem      [DEPTH];
    logic [WIDTH-1:0] pc_mem      [DEPTH];
    logic [WIDTH-1:0] next_pc_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ir_mem[wr_ptr]      <= enq_ir;
            pc_mem[wr_ptr]      <= enq_pc;
            next_pc_mem[wr_ptr] <= enq_next_pc;
        end
    end

    assign head_ir      = ir_mem[rd_ptr];
    assign head_pc      = pc_mem[rd_ptr];
    assign head_next_pc = next_pc_mem[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// LC-3b instruction prefetcher: owns the PC, runs one blocking icache request at a time
// and buffers returned instructions so decode stalls do not stall the icache.
module prefetch_unit
    import lc3b_types::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter int               INC      = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(LC3B_RESET_PC)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         redirect,
    input  logic [WIDTH-1:0]             redirect_pc,
    output logic                         icache_read,
    output logic [WIDTH-1:0]             icache_address,
    input  logic [WIDTH-1:0]             icache_rdata,
    input  logic                         icache_resp,
    input  logic                         de_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_ir,
    output logic [WIDTH-1:0]             out_pc,
    output logic [WIDTH-1:0]             out_next_pc,
    output prefetch_state_t              state,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    // Handshakes: icache_read rises with a stable icache_address and stays high until the
    // single-cycle icache_resp; an entry leaves the queue when out_valid && de_ready && !redirect.

    localparam int               CW    = $clog2(DEPTH+1);
    localparam logic [CW-1:0]    FULL  = CW'(DEPTH);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    prefetch_state_t  cur_state;
    prefetch_state_t  next_state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_next;
    logic [WIDTH-1:0] req_inc;
    logic             enq;
    logic             deq;
    logic [CW-1:0]    count_after;

    assign req_inc        = req_addr + INC_W;
    assign icache_read    = reset_n && (cur_state != IDLE);
    assign icache_address = req_addr;
    assign out_valid      = reset_n && (count != '0);
    assign enq            = (cur_state == FETCH) && icache_resp && !redirect;
    assign deq            = out_valid && de_ready && !redirect;
    assign state          = cur_state;

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .enq          (enq),
        .deq          (deq),
        .flush        (redirect),
        .enq_ir       (icache_rdata),
        .enq_pc       (req_addr),
        .enq_next_pc  (req_inc),
        .count        (count),
        .head_ir      (out_ir),
        .head_pc      (out_pc),
        .head_next_pc (out_next_pc)
    );

    // Occupancy after this cycle's enqueue/dequeue decides whether to chain the next request.
    always_comb begin
        count_after = count;
        if (enq && !deq)      count_after = count + 1'b1;
        else if (!enq && deq) count_after = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
        end else begin
            cur_state <= next_state;
            pc        <= pc_next;
            req_addr  <= req_next;
        end
    end

    always_comb begin
        next_state = cur_state;
        pc_next    = pc;
        req_next   = req_addr;
        case (cur_state)
            IDLE: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    req_next   = redirect_pc;
                    next_state = FETCH;
                end else if (count < FULL) begin
                    req_next   = pc;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                    // An outstanding address is never changed; wait out the stale access.
                    if (icache_resp) req_next = redirect_pc;
                    else             next_state = DISCARD;
                end else if (icache_resp) begin
                    pc_next = req_inc;
                    if (count_after < FULL) req_next = req_inc;
                    else                    next_state = IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                    if (icache_resp) begin
                        req_next   = redirect_pc;
                        next_state = FETCH;
                    end
                end else if (icache_resp) begin
                    req_next   = pc;
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

endmodule
